raptor64_regfile_byp: RTL and testbench
=======================================

Name: raptor64_regfile_byp

Overview:
Parametrised successor to the Raptor64 register file with bypass muxes. Provides NRD synchronous read ports over a 2^AWID x WID array, one write port, and NSTAGES explicitly-validated bypass sources. Read results are registered. A post-reset clear sequencer zeroes the whole array before reads and writes are accepted. Sits between the decode stage (addresses, dpc) and the execute stage (operand registers).

Parameters:
WID, 64, data width in bits
AWID, 9, register address width; depth is 2^AWID
NRD, 3, number of read ports
NSTAGES, 5, number of bypass sources; index 0 is the youngest (x), NSTAGES-1 the oldest
PCREG, 29, value of address bits [4:0] that selects dpc

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
advanceR  in  1  capture read results this cycle
advanceW  in  1  perform the write this cycle
rRa  in  NRD*AWID  packed read addresses; port k occupies [k*AWID +: AWID]
dpc  in  WID  decode-stage PC
wRt  in  AWID  write address
wData  in  WID  write data
byRt  in  NSTAGES*AWID  packed bypass target addresses
byData  in  NSTAGES*WID  packed bypass data
byValid  in  NSTAGES  per-stage bypass valid
rdo  out  NRD*WID  registered read data, packed
rbyp  out  NRD  registered; 1 = port k value came from a bypass source or the write port
busy  out  1  1 while the clear sequencer runs

Behaviour:
- Reset: rdo=0, rbyp=0, busy=1, state=CLEAR, clear counter=0.
- FSM states:
  - CLEAR: writes 0 to array[cnt] each cycle and increments cnt. When cnt = 2^AWID-1, that last word is written and the next state is RUN with busy=0. Total busy time is 2^AWID cycles after rst deasserts.
  - RUN: normal operation.
- rst asserted in any state, including mid-CLEAR: returns to reset values and restarts the clear at address 0.
- While busy:
  - advanceW and advanceR are ignored.
  - The array is not written from wRt/wData.
  - rdo and rbyp hold their values.
- Write (RUN): on a rising edge with advanceW=1, array[wRt] <= wData. Address 0 is stored like any other address but reads of it return 0.
- Read (RUN): on a rising edge with advanceR=1, each port k registers rdo[k] <= resolve(rRa[k]). Latency is 1 cycle. With advanceR=0, rdo and rbyp hold.
- resolve(a), first match wins:
  1. a[4:0]==0 -> 0, rbyp=0.
  2. a[4:0]==PCREG -> dpc, rbyp=0.
  3. Lowest index i with byValid[i]=1 and byRt[i]==a -> byData[i], rbyp=1.
  4. advanceW=1 and wRt==a -> wData (same-cycle write forwarding), rbyp=1.
  5. Otherwise array[a] as it was before this edge's write, rbyp=0.
- Rules 1 and 2 compare only bits [4:0] and ignore the upper bits (bank bits), matching the existing convention.
- Bypass entries with byValid=0 never match, even when byRt equals the address.
- Array read is synchronous on the array side. Implementation may use NRD replicated block RAMs sharing the write port, or distributed RAM. Rule 5 value must be the pre-write content.
- Simultaneous advanceR and advanceW to the same address: returns wData per rule 4, unless a valid bypass stage also matches, in which case rule 3 wins.
- All ports resolve independently and may use the same address.

Test Plan:
- Clear: pulse rst with AWID=4. Response: busy=1 for exactly 16 cycles after rst falls, then 0. Reading addresses 1..15 then gives rdo=0 and rbyp=0.
- Write/read: in RUN, write 0x1234 to address 7. Next cycle, with advanceR and rRa port0=7 and all byValid=0, rdo[0]=0x1234 one edge later, rbyp[0]=0.
- Specials: write 0xFFFF to address 0 and to 0x20. Read 0x000 -> 0. Read 0x020 -> 0. Read 0x01D with dpc=0xABCD -> 0xABCD. Read 0x03D -> 0xABCD.
- Bypass priority: stage0 and stage2 both valid for address 5 with data 0xA and 0xC, plus a same-cycle write of 0xF to address 5. Result: rdo=0xA, rbyp=1. Drop byValid[0]: rdo=0xC. Drop all byValid: rdo=0xF.
- Hold and gating: advanceR=0 with changing addresses -> rdo unchanged. A write during busy is ignored: the address still reads 0 after the clear completes.
- Reset mid-clear: assert rst at clear count 9 -> busy stays 1 for a full 2^AWID cycles after rst falls, and rdo=0.

Source files
------------

// File: rtl/raptor64_regfile_byp.sv
// Raptor64 register file: NRD registered read ports, one write port,
// NSTAGES validated bypass sources and a post-reset clear of the whole array.
module raptor64_regfile_byp #(
  parameter int WID     = 64,
  parameter int AWID    = 9,
  parameter int NRD     = 3,
  parameter int NSTAGES = 5,
  parameter int PCREG   = 29
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    advanceR,
  input  logic                    advanceW,
  input  logic [NRD*AWID-1:0]     rRa,
  input  logic [WID-1:0]          dpc,
  input  logic [AWID-1:0]         wRt,
  input  logic [WID-1:0]          wData,
  input  logic [NSTAGES*AWID-1:0] byRt,
  input  logic [NSTAGES*WID-1:0]  byData,
  input  logic [NSTAGES-1:0]      byValid,
  output logic [NRD*WID-1:0]      rdo,
  output logic [NRD-1:0]          rbyp,
  output logic                    busy
);

  // state | meaning
  // CLEAR | zeroing array[cnt] once per cycle; busy=1, reads/writes ignored
  // RUN   | normal read, write and bypass operation
  typedef enum logic {CLEAR, RUN} state_t;

  localparam int              DEPTH    = 2**AWID;
  localparam logic [4:0]      PC_SEL   = 5'(PCREG);
  localparam logic [AWID-1:0] CNT_LAST = '1;

  state_t          state_q, state_d;
  logic [AWID-1:0] cnt_q, cnt_d;
  logic            rd_en;

  logic [WID-1:0] mem [DEPTH];
  logic [WID-1:0] res_d [NRD];
  logic [NRD-1:0] res_b;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      CLEAR: begin
        cnt_d = cnt_q + AWID'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      RUN:     state_d = RUN;
      default: state_d = CLEAR;
    endcase
  end

  assign busy  = (state_q == CLEAR);
  assign rd_en = (state_q == RUN) && advanceR;

  // The clear sequencer owns the write port while busy.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (busy)
        mem[cnt_q] <= '0;
      else if (advanceW)
        mem[wRt] <= wData;
    end
  end

  // Priority is built lowest-first so the last assignment that hits wins:
  // array < write forward < bypass (oldest..youngest) < dpc < zero register.
  always_comb begin
    for (int k = 0; k < NRD; k++) begin
      res_d[k] = mem[rRa[k*AWID +: AWID]];
      res_b[k] = 1'b0;
      if (advanceW && (wRt == rRa[k*AWID +: AWID])) begin
        res_d[k] = wData;
        res_b[k] = 1'b1;
      end
      for (int i = NSTAGES - 1; i >= 0; i--) begin
        if (byValid[i] && (byRt[i*AWID +: AWID] == rRa[k*AWID +: AWID])) begin
          res_d[k] = byData[i*WID +: WID];
          res_b[k] = 1'b1;
        end
      end
      if (rRa[k*AWID +: 5] == PC_SEL) begin
        res_d[k] = dpc;
        res_b[k] = 1'b0;
      end
      if (rRa[k*AWID +: 5] == 5'd0) begin
        res_d[k] = '0;
        res_b[k] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdo  <= '0;
      rbyp <= '0;
    end else if (rd_en) begin
      for (int k = 0; k < NRD; k++)
        rdo[k*WID +: WID] <= res_d[k];
      rbyp <= res_b;
    end
  end

endmodule

// File: tb/tb_raptor64_regfile_byp.sv
// Scoreboard bench for raptor64_regfile_byp: expected reads are queued when
// stimulus is applied and compared after the capturing edge.
module tb_raptor64_regfile_byp;
  localparam int WID = 16, AWID = 6, NRD = 3, NSTAGES = 5, PCREG = 29;
  localparam int DEPTH = 2**AWID;

  logic                    clk = 1'b0;
  logic                    rst, advanceR, advanceW;
  logic [NRD*AWID-1:0]     rRa;
  logic [WID-1:0]          dpc, wData;
  logic [AWID-1:0]         wRt;
  logic [NSTAGES*AWID-1:0] byRt;
  logic [NSTAGES*WID-1:0]  byData;
  logic [NSTAGES-1:0]      byValid;
  logic [NRD*WID-1:0]      rdo;
  logic [NRD-1:0]          rbyp;
  logic                    busy;

  int checks = 0, errors = 0;

  typedef struct {
    int             port;
    logic [WID-1:0] d;
    logic           b;
  } exp_t;
  exp_t sb[$];
  logic [WID-1:0] hold_d [NRD];
  logic           hold_b [NRD];
  logic [WID-1:0] model [DEPTH];

  raptor64_regfile_byp #(.WID(WID), .AWID(AWID), .NRD(NRD), .NSTAGES(NSTAGES), .PCREG(PCREG)) dut (
    .clk(clk), .rst(rst), .advanceR(advanceR), .advanceW(advanceW), .rRa(rRa), .dpc(dpc),
    .wRt(wRt), .wData(wData), .byRt(byRt), .byData(byData), .byValid(byValid),
    .rdo(rdo), .rbyp(rbyp), .busy(busy));

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_ra(input int k, input logic [AWID-1:0] a);
    rRa[k*AWID +: AWID] = a;
  endtask

  task automatic set_by(input int i, input logic [AWID-1:0] a, input logic [WID-1:0] d, input logic v);
    byRt[i*AWID +: AWID] = a;
    byData[i*WID +: WID] = d;
    byValid[i] = v;
  endtask

  task automatic push_exp(input int k, input logic [WID-1:0] d, input logic b);
    exp_t e;
    e.port = k; e.d = d; e.b = b;
    sb.push_back(e);
  endtask

  task automatic write_word(input logic [AWID-1:0] a, input logic [WID-1:0] d);
    advanceW = 1'b1; wRt = a; wData = d;
    tick();
    advanceW = 1'b0;
    model[a] = d;
  endtask

  task automatic test_reset;
    int n;
    rst = 1'b1;
    tick(); tick();
    checks++; if (rdo !== '0) begin errors++; $display("FAIL reset_rdo: got %h want 0", rdo); end
    checks++; if (rbyp !== '0) begin errors++; $display("FAIL reset_rbyp: got %b want 0", rbyp); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy: got %b want 1", busy); end
    // Writes and reads offered throughout the clear must be ignored.
    advanceW = 1'b1; wRt = 6'd9; wData = 16'h5555;
    advanceR = 1'b1;
    for (int k = 0; k < NRD; k++) set_ra(k, 6'd9);
    rst = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      tick();
      n++;
    end
    checks++; if (n !== DEPTH) begin errors++; $display("FAIL clear_len: busy cycles %0d want %0d", n, DEPTH); end
    checks++; if (rdo !== '0 || rbyp !== '0) begin
      errors++; $display("FAIL busy_hold: rdo=%h rbyp=%b want 0/0", rdo, rbyp);
    end
    advanceW = 1'b0; advanceR = 1'b0;
    for (int a = 0; a < DEPTH; a++) model[a] = '0;
  endtask

  task automatic test_clear_zero;
    exp_t e;
    advanceR = 1'b1;
    for (int r = 0; r < 5; r++) begin
      for (int k = 0; k < NRD; k++) begin
        set_ra(k, AWID'(1 + r*NRD + k));
        push_exp(k, '0, 1'b0);
      end
      tick();
      while (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (rdo[e.port*WID +: WID] !== e.d || rbyp[e.port] !== e.b) begin
          errors++;
          $display("FAIL clear_zero row%0d port%0d: rdo=%h rbyp=%b want %h/%b", r, e.port, rdo[e.port*WID +: WID], rbyp[e.port], e.d, e.b);
        end
        hold_d[e.port] = e.d; hold_b[e.port] = e.b;
      end
    end
    advanceR = 1'b0;
  endtask

  task automatic test_write_read;
    exp_t e;
    write_word(6'd7, 16'h1234);
    advanceR = 1'b1;
    set_ra(0, 6'd7); push_exp(0, 16'h1234, 1'b0);
    set_ra(1, 6'd8); push_exp(1, 16'h0000, 1'b0);
    set_ra(2, 6'd7); push_exp(2, 16'h1234, 1'b0);
    tick();
    advanceR = 1'b0;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (rdo[e.port*WID +: WID] !== e.d || rbyp[e.port] !== e.b) begin
        errors++;
        $display("FAIL write_read port%0d: rdo=%h rbyp=%b want %h/%b", e.port, rdo[e.port*WID +: WID], rbyp[e.port], e.d, e.b);
      end
      hold_d[e.port] = e.d; hold_b[e.port] = e.b;
    end
  endtask

  task automatic test_specials;
    exp_t e;
    write_word(6'h00, 16'hFFFF);
    write_word(6'h20, 16'hFFFF);
    dpc = 16'hABCD;
    for (int step = 0; step < 2; step++) begin
      advanceR = 1'b1;
      if (step == 0) begin
        // Valid bypasses on special addresses must lose to zero/dpc.
        set_by(0, 6'h20, 16'h1111, 1'b1);
        set_by(1, 6'h1D, 16'h2222, 1'b1);
        set_ra(0, 6'h00); push_exp(0, 16'h0000, 1'b0);
        set_ra(1, 6'h20); push_exp(1, 16'h0000, 1'b0);
        set_ra(2, 6'h1D); push_exp(2, 16'hABCD, 1'b0);
      end else begin
        byValid = '0;
        set_ra(0, 6'h3D); push_exp(0, 16'hABCD, 1'b0);
        set_ra(1, 6'h1E); push_exp(1, 16'h0000, 1'b0);
        set_ra(2, 6'h07); push_exp(2, 16'h1234, 1'b0);
      end
      tick();
      while (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (rdo[e.port*WID +: WID] !== e.d || rbyp[e.port] !== e.b) begin
          errors++;
          $display("FAIL specials step%0d port%0d: rdo=%h rbyp=%b want %h/%b", step, e.port, rdo[e.port*WID +: WID], rbyp[e.port], e.d, e.b);
        end
        hold_d[e.port] = e.d; hold_b[e.port] = e.b;
      end
    end
    advanceR = 1'b0;
  endtask

  task automatic test_bypass_priority;
    exp_t e;
    set_by(0, 6'd5, 16'h000A, 1'b1);
    set_by(1, 6'd5, 16'h000B, 1'b0);
    set_by(2, 6'd5, 16'h000C, 1'b1);
    for (int step = 0; step < 4; step++) begin
      advanceR = 1'b1;
      advanceW = (step < 3); wRt = 6'd5; wData = 16'h000F;
      set_ra(0, 6'd5); set_ra(1, 6'd7); set_ra(2, 6'd5);
      case (step)
        0: begin push_exp(0, 16'h000A, 1'b1); push_exp(2, 16'h000A, 1'b1); end
        1: begin byValid[0] = 1'b0; push_exp(0, 16'h000C, 1'b1); push_exp(2, 16'h000C, 1'b1); end
        2: begin byValid = '0; push_exp(0, 16'h000F, 1'b1); push_exp(2, 16'h000F, 1'b1); end
        default: begin push_exp(0, 16'h000F, 1'b0); push_exp(2, 16'h000F, 1'b0); end
      endcase
      push_exp(1, 16'h1234, 1'b0);
      tick();
      while (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (rdo[e.port*WID +: WID] !== e.d || rbyp[e.port] !== e.b) begin
          errors++;
          $display("FAIL bypass step%0d port%0d: rdo=%h rbyp=%b want %h/%b", step, e.port, rdo[e.port*WID +: WID], rbyp[e.port], e.d, e.b);
        end
        hold_d[e.port] = e.d; hold_b[e.port] = e.b;
      end
    end
    advanceR = 1'b0; advanceW = 1'b0;
    model[5] = 16'h000F;
  endtask

  task automatic test_hold;
    advanceR = 1'b0;
    for (int c = 0; c < 3; c++) begin
      for (int k = 0; k < NRD; k++) set_ra(k, AWID'(10 + c + k));
      set_by(0, AWID'(10 + c), 16'h7777, 1'b1);
      dpc = 16'h0BAD;
      tick();
      for (int k = 0; k < NRD; k++) begin
        checks++;
        if (rdo[k*WID +: WID] !== hold_d[k] || rbyp[k] !== hold_b[k]) begin
          errors++;
          $display("FAIL hold cyc%0d port%0d: rdo=%h rbyp=%b want %h/%b", c, k, rdo[k*WID +: WID], rbyp[k], hold_d[k], hold_b[k]);
        end
      end
    end
    byValid = '0;
  endtask

  task automatic test_back_to_back;
    exp_t e;
    for (int a = 10; a < 18; a++) write_word(AWID'(a), WID'(16'h1000 + a*3));
    advanceR = 1'b1;
    for (int c = 0; c < 8; c++) begin
      for (int k = 0; k < NRD; k++) begin
        set_ra(k, AWID'(10 + (c + k*3) % 8));
        push_exp(k, model[10 + (c + k*3) % 8], 1'b0);
      end
      tick();
      while (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (rdo[e.port*WID +: WID] !== e.d || rbyp[e.port] !== e.b) begin
          errors++;
          $display("FAIL back_to_back cyc%0d port%0d: rdo=%h rbyp=%b want %h/%b", c, e.port, rdo[e.port*WID +: WID], rbyp[e.port], e.d, e.b);
        end
        hold_d[e.port] = e.d; hold_b[e.port] = e.b;
      end
    end
    advanceR = 1'b0;
  endtask

  task automatic test_reset_midclear;
    exp_t e;
    int n;
    rst = 1'b1; tick(); rst = 1'b0;
    for (int c = 0; c < 9; c++) tick();
    rst = 1'b1; tick();
    checks++; if (rdo !== '0 || rbyp !== '0 || busy !== 1'b1) begin
      errors++; $display("FAIL midclear_reset: rdo=%h rbyp=%b busy=%b want 0/0/1", rdo, rbyp, busy);
    end
    rst = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      tick();
      n++;
    end
    checks++; if (n !== DEPTH) begin errors++; $display("FAIL midclear_len: busy cycles %0d want %0d", n, DEPTH); end
    advanceR = 1'b1;
    set_ra(0, 6'd7);  push_exp(0, 16'h0000, 1'b0);
    set_ra(1, 6'd12); push_exp(1, 16'h0000, 1'b0);
    set_ra(2, 6'd5);  push_exp(2, 16'h0000, 1'b0);
    tick();
    advanceR = 1'b0;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (rdo[e.port*WID +: WID] !== e.d || rbyp[e.port] !== e.b) begin
        errors++;
        $display("FAIL midclear_read port%0d: rdo=%h rbyp=%b want %h/%b", e.port, rdo[e.port*WID +: WID], rbyp[e.port], e.d, e.b);
      end
    end
  endtask

  initial begin
    rst = 1'b1; advanceR = 1'b0; advanceW = 1'b0;
    rRa = '0; dpc = '0; wRt = '0; wData = '0;
    byRt = '0; byData = '0; byValid = '0;
    for (int k = 0; k < NRD; k++) begin hold_d[k] = '0; hold_b[k] = 1'b0; end
    test_reset();
    test_clear_zero();
    test_write_read();
    test_specials();
    test_bypass_priority();
    test_hold();
    test_back_to_back();
    test_reset_midclear();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
